clz_tree: RTL and testbench
===========================

# clz_tree

Parameterised count-leading-zeros unit. It takes a `bits_in`-wide word and returns the number of zero bits above the most significant one, plus a flag that is set when the word is non-zero. Internally it is a binary tree of two-input merge cells with one output register stage. It serves normalisation and priority logic in the datapath.

## Interface
- `bits_in`, default 16: input width; a power of two, 2 or greater.
- `bits_out`, derived localparam, equal to clog2(`bits_in`) (4 for the default): count width. It is not overridable.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `b`  in  `bits_in`  word to scan; bit `bits_in`-1 is the leading (MSB) position.
- `pout`  out  `bits_out`  registered leading-zero count.
- `vout`  out  1  registered valid flag; 1 when `b` was non-zero.

## Operation
- Leaves: each input bit i gives a 1-bit node with v = b[i] and an empty position field.
- Merge cell (`clz_merge`, parameter N = position width of the children, giving output width N+1). Inputs are the left (more significant) child `vl`, `pl`[N] and the right child `vr`, `pr`[N]. Outputs:
  - `vg` = `vl` | `vr`.
  - `pg` = {1'b0, `pl`} when `vl` = 1, otherwise {1'b1, `pr`}. The prepended bit is the new MSB.
- The tree has clog2(`bits_in`) merge levels. The root gives the next-state `vout` and `pout`.
- Result for non-zero `b`: `pout` = `bits_in`-1-(index of the highest set bit), with range 0..`bits_in`-1. `vout` = 1.
- `b` = 0: `vout` = 0 and `pout` = all ones (`bits_in`-1). This falls naturally out of the merge rule. Consumers must qualify `pout` with `vout`.
- The merge cell is purely combinational.

## Timing
- `b` is sampled every rising edge. `pout` and `vout` show the result for that sample on the next edge, so latency is 1 cycle.
- Throughput is one word per cycle. There is no handshake and no stall.
- Reset: while `rst` is high at an edge, `pout` = 0 and `vout` = 0 after that edge. Input is ignored on that edge.
- Reset mid-stream: the in-flight result is discarded. The first valid output appears one edge after the first non-reset sample edge.
- The tree is combinational between the input and the register, so the critical path is clog2(`bits_in`) mux levels.

## Structure
- Shared package `clz_pkg`: a clog2 constant function, and the reset values of `pout` and `vout` (both zero).
- Sub-module `clz_merge`, parameter N, is the merge cell. It is instantiated per node by generate loops over the levels.
- The top level holds the generate tree plus the output register. The root sits at level clog2(`bits_in`).

## Test plan
- Merge cell with N=3, `pl`=111, `pr`=000:
  - `vl`=0, `vr`=0 -> `vg`=0, `pg`=1000.
  - `vl`=0, `vr`=1 -> `vg`=1, `pg`=1000.
  - `vl`=1, `vr`=0 -> `vg`=1, `pg`=0111.
  - `vl`=1, `vr`=1 -> `vg`=1, `pg`=0111.
- Default width, `b`=16'h0000 -> one cycle later `vout`=0, `pout`=4'b1111. Then `b`=16'h0001 -> `vout`=1, `pout`=15.
- `b`=16'hFFF7 -> `pout`=0, `vout`=1. Then `b`=16'h0008 -> `pout`=12, `vout`=1.
- Walking one, `b`=1<<k for k=0..15 on back-to-back cycles -> each cycle `pout`=15-k, `vout`=1, with 1-cycle latency and no bubbles.
- Assert `rst` while `b`=16'h0100 is streaming -> after that edge `pout`=0, `vout`=0. Release `rst` -> the next edge gives `pout`=7, `vout`=1.
- Set `bits_in`=2 and `bits_in`=32. Run exhaustive (2-bit) or random (32-bit) inputs against a reference model that counts leading zeros from the MSB.

Source files
------------

// File: rtl/clz_pkg.sv
// Shared constants and helpers for the count-leading-zeros tree.
package clz_pkg;

    localparam int  POUT_RST = 0;
    localparam logic VOUT_RST = 1'b0;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clz_merge.sv
// Two-input merge cell of the CLZ tree: picks the left child's position when it
// holds a one, otherwise the right child's, and prepends the new count MSB.
module clz_merge #(
    parameter int N = 1
) (
    input  logic         vl,
    input  logic [N-1:0] pl,
    input  logic         vr,
    input  logic [N-1:0] pr,
    output logic         vg,
    output logic [N:0]   pg
);

    assign vg = vl | vr;
    assign pg = vl ? {1'b0, pl} : {1'b1, pr};

endmodule

// File: rtl/clz_tree.sv
// Count-leading-zeros unit: combinational merge tree over the input word,
// followed by a single output register stage.
module clz_tree
    import clz_pkg::*;
#(
    parameter  int bits_in  = 16,
    localparam int bits_out = clog2(bits_in)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [bits_in-1:0]  b,
    output logic [bits_out-1:0] pout,
    output logic                vout
);

    logic [bits_out-1:0] pout_p0;
    logic                vout_p0;

    // Level l holds bits_in>>l nodes with an l-bit position field; level 1
    // merges raw bit pairs, whose empty position fields reduce the mux to ~b[hi].
    for (genvar l = 1; l <= bits_out; l++) begin : lvl_g
        localparam int NODES = bits_in >> l;
        logic [NODES-1:0] v;
        logic [l-1:0]     p [NODES];

        for (genvar j = 0; j < NODES; j++) begin : node_g
            if (l == 1) begin : leaf_g
                assign v[j] = b[2*j+1] | b[2*j];
                assign p[j] = ~b[2*j+1];
            end else begin : merge_g
                clz_merge #(.N(l-1)) u_merge (
                    .vl (lvl_g[l-1].v[2*j+1]),
                    .pl (lvl_g[l-1].p[2*j+1]),
                    .vr (lvl_g[l-1].v[2*j]),
                    .pr (lvl_g[l-1].p[2*j]),
                    .vg (v[j]),
                    .pg (p[j])
                );
            end
        end
    end

    assign vout_p0 = lvl_g[bits_out].v[0];
    assign pout_p0 = lvl_g[bits_out].p[0];

    // p0 -> output register
    always_ff @(posedge clk) begin
        if (rst) begin
            pout <= bits_out'(POUT_RST);
            vout <= VOUT_RST;
        end else begin
            pout <= pout_p0;
            vout <= vout_p0;
        end
    end

endmodule

// File: tb/tb_clz_tree.sv
// Scoreboard bench for clz_tree at widths 16, 2 and 32, plus the merge cell alone.
module tb_clz_tree;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] b16 = '0;
    logic [1:0]  b2  = '0;
    logic [31:0] b32 = '0;
    logic [3:0]  p16;
    logic        v16;
    logic        p2;
    logic        v2;
    logic [4:0]  p32;
    logic        v32;

    logic       mvl = 1'b0, mvr = 1'b0, mvg;
    logic [2:0] mpl = 3'b111, mpr = 3'b000;
    logic [3:0] mpg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] p16; logic v16;
        logic       p2;  logic v2;
        logic [4:0] p32; logic v32;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    clz_tree #(.bits_in(16)) u_d16 (.clk(clk), .rst(rst), .b(b16), .pout(p16), .vout(v16));
    clz_tree #(.bits_in(2))  u_d2  (.clk(clk), .rst(rst), .b(b2),  .pout(p2),  .vout(v2));
    clz_tree #(.bits_in(32)) u_d32 (.clk(clk), .rst(rst), .b(b32), .pout(p32), .vout(v32));

    clz_merge #(.N(3)) u_merge (.vl(mvl), .pl(mpl), .vr(mvr), .pr(mpr), .vg(mvg), .pg(mpg));

    function automatic int clz_ref(input logic [31:0] x, input int w);
        for (int i = w - 1; i >= 0; i--)
            if (x[i]) return w - 1 - i;
        return w - 1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive one sample on the falling edge and queue what the next rising edge must show.
    task automatic step(input logic [15:0] x16, input int ep16, input logic ev16,
                        input logic [1:0] x2, input logic [31:0] x32, input logic r);
        exp_t e;
        @(negedge clk);
        rst = r; b16 = x16; b2 = x2; b32 = x32;
        if (r) begin
            e = '{p16: 4'd0, v16: 1'b0, p2: 1'b0, v2: 1'b0, p32: 5'd0, v32: 1'b0};
        end else begin
            e.p16 = 4'(ep16);
            e.v16 = ev16;
            e.p2  = 1'(clz_ref({30'd0, x2}, 2));
            e.v2  = |x2;
            e.p32 = 5'(clz_ref(x32, 32));
            e.v32 = |x32;
        end
        q.push_back(e);
    endtask

    // Monitor: every rising edge with an outstanding sample, compare all three DUTs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("p16", int'(p16), int'(e.p16));
            check("v16", int'(v16), int'(e.v16));
            check("p2",  int'(p2),  int'(e.p2));
            check("v2",  int'(v2),  int'(e.v2));
            check("p32", int'(p32), int'(e.p32));
            check("v32", int'(v32), int'(e.v32));
        end
    end

    initial begin
        logic [1:0] vv;
        logic [31:0] r32;
        int drained;

        for (int k = 0; k < 4; k++) begin
            vv = 2'(k);
            mvl = vv[1]; mvr = vv[0];
            #1;
            check("merge_vg", int'(mvg), (k == 0) ? 0 : 1);
            check("merge_pg", int'(mpg), vv[1] ? 4'b0111 : 4'b1000);
        end

        step(16'h1234, 0, 1'b0, 2'b11, 32'hFFFF_FFFF, 1'b1);
        step(16'h1234, 0, 1'b0, 2'b11, 32'hFFFF_FFFF, 1'b1);

        step(16'h0000, 15, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        step(16'h0001, 15, 1'b1, 2'b01, 32'h0000_0001, 1'b0);
        step(16'hFFF7, 0,  1'b1, 2'b10, 32'h8000_0000, 1'b0);
        step(16'h0008, 12, 1'b1, 2'b11, 32'h0001_0000, 1'b0);

        for (int k = 0; k < 16; k++)
            step(16'(1 << k), 15 - k, 1'b1, 2'(k), 32'(1) << (2 * k + 1), 1'b0);

        step(16'h0100, 7, 1'b1, 2'b01, 32'h0000_0100, 1'b0);
        step(16'h0100, 0, 1'b0, 2'b01, 32'h0000_0100, 1'b1);
        step(16'h0100, 7, 1'b1, 2'b01, 32'h0000_0100, 1'b0);

        for (int k = 0; k < 4; k++)
            step(16'h0000, 15, 1'b0, 2'(k), 32'(k), 1'b0);

        for (int k = 0; k < 40; k++) begin
            r32 = $urandom() >> (k % 32);
            step(16'h8000, 0, 1'b1, 2'(k), r32, 1'b0);
        end

        drained = 0;
        for (int c = 0; c < 10 && drained == 0; c++) begin
            @(negedge clk);
            if (q.size() == 0) drained = 1;
        end
        if (drained == 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
